mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the single-cycle core's data bus, beside the data memory. It decodes the same store/load signals the core drives to data memory: stores to its DATA register queue a byte, loads from STATUS report state. A small FIFO decouples the core from the serial line, and a baud-timed FSM shifts frames out on `Tx_o`. The top level muxes `Read_Data_o` into the load path when `Hit_o` is high.

---
 rtl/mmio_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter: DATA/STATUS decode, byte FIFO, baud-timed frame FSM.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 instead of 8N1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Hit_o,
  output logic        Tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [29:0]   DATA_WA   = BASE_ADDR[31:2];
  localparam logic [29:0]   STAT_WA   = DATA_WA + 30'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic        sel_data, sel_stat;
  logic        fifo_empty, fifo_full, baud_done, busy;
  logic        push_req, push, pop;
  logic [7:0]  pop_data;
  logic [31:0] count_ext;
  logic [3:0]  count_disp;
  logic [31:0] status_w;

  assign sel_data   = (Address_i[31:2] == DATA_WA);
  assign sel_stat   = (Address_i[31:2] == STAT_WA);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign baud_done  = (baud_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign pop_data   = mem_q[rd_ptr_q];

  // The FSM pops from IDLE, or at the last STOP cycle so frames run back-to-back.
  assign pop      = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_done));
  assign push_req = Mem_Write_i && sel_data;
  assign push     = push_req && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (Mem_Read_i && sel_stat) ovf_d = 1'b0;
    if (push_req && !push)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= Write_Data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= pop_data;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q <= ^pop_data;
`endif
            baud_q  <= BAUD_LOAD;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            state_q   <= S_DATA;
            baud_q    <= BAUD_LOAD;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            state_q <= S_STOP;
            baud_q  <= BAUD_LOAD;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= pop_data;
`ifdef MMIO_UART_TX_PARITY_EN
              parity_q <= ^pop_data;
`endif
              baud_q  <= BAUD_LOAD;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign count_ext  = 32'(count_q);
  assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_w   = {24'b0, count_disp, ovf_q, fifo_empty, fifo_full, busy};

  assign Read_Data_o = sel_stat ? status_w : 32'b0;
  assign Hit_o       = sel_data || sel_stat;
  assign Tx_o        = tx_q;

  wire unused_bits = &{1'b0, Write_Data_i[31:8], Address_i[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx: queued expected bytes, line monitor, directed and random stores.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = FB * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mw = 1'b0;
  logic        mr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Mem_Write_i(mw), .Mem_Read_i(mr), .Address_i(addr),
    .Write_Data_i(wdata), .Read_Data_o(rdata), .Hit_o(hit), .Tx_o(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Line level of bit slot k in a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin : monitor
    logic [7:0]  b;
    logic [63:0] got_v, exp_v;
    bit aborted, had_exp;
    forever begin
      @(negedge clk); #2;
      if (!reset && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        got_v = '0; exp_v = '0; aborted = 1'b0;
        had_exp = (exp_q.size() != 0);
        if (!had_exp) begin
          check("unexpected_frame", 1, 0);
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        for (int i = 0; i < FL; i++) begin
          if (i > 0) begin @(negedge clk); #2; end
          if (reset) begin aborted = 1'b1; break; end
          got_v[i] = tx;
          exp_v[i] = frame_bit(b, i / CPB);
        end
        if (aborted) exp_q.delete();
        else if (had_exp) check("frame", got_v, exp_v);
      end
    end
  end

  task automatic store(input logic [7:0] b);
    logic [31:0] r;
    r = $urandom;
    addr = BASE; wdata = {r[31:8], b}; mw = 1'b1;
    @(negedge clk);
    mw = 1'b0;
  endtask

  task automatic peek(output logic [31:0] s);
    mr = 1'b0; addr = BASE + 32'd4;
    #1 s = rdata;
  endtask

  initial begin : stim
    logic [31:0] s, a, base_v;
    logic [7:0]  b;
    int t, gap;
    base_v = BASE;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_tx", tx, 1);
    peek(s); check("reset_status", s, 32'h04);
    addr = BASE + 32'd4; #1 check("hit_status", hit, 1);
    addr = BASE + 32'd8; #1 check("hit_beyond", hit, 0);
    addr = BASE + 32'd3; #1 check("hit_low_bits", hit, 1);
    addr = BASE; #1 check("data_read_zero", rdata, 0);

    @(negedge clk);
    exp_q.push_back(8'h55); store(8'h55);
    #1 check("tx_high_after_store", tx, 1);
    @(negedge clk); #1 check("start_latency", tx, 0);
    repeat (FL) @(negedge clk);
    peek(s); check("single_idle_status", s, 32'h04);

    repeat (4) @(negedge clk);
    start_cyc.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    store(8'hA5); store(8'h3C);
    peek(s); check("b2b_count1", s, 32'h11);
    repeat (FL) @(negedge clk);
    peek(s); check("b2b_count0", s, 32'h05);
    repeat (FL + 4) @(negedge clk);
    check("b2b_frames", start_cyc.size(), 2);
    if (start_cyc.size() >= 2) check("b2b_gap", start_cyc[1] - start_cyc[0], FL);

    exp_q.push_back(8'h11); store(8'h11);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(b);
      store(b);
    end
    peek(s); check("ovf_status", s, 32'h4B);
    mr = 1'b1; addr = BASE + 32'd4;
    @(negedge clk);
    mr = 1'b0;
    peek(s); check("ovf_cleared", s, 32'h43);
    repeat (FL - 8) @(negedge clk);
    b = 8'($urandom); exp_q.push_back(b); store(b);
    peek(s); check("full_pop_store", s, 32'h43);
    repeat (5 * FL + 4) @(negedge clk);
    peek(s); check("ovf_drained", s, 32'h04);

    exp_q.push_back(8'h5A); store(8'h5A);
    exp_q.push_back(8'h01); store(8'h01);
    exp_q.push_back(8'h02); store(8'h02);
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("midframe_reset_tx", tx, 1);
    peek(s); check("midframe_reset_status", s, 32'h04);
    repeat (2 * FL) @(negedge clk);
    check("midframe_no_frames", tx, 1);

    exp_q.push_back(8'h07); store(8'h07);
    repeat (FL) @(negedge clk);
    peek(s); check("frame_len_busy", s, 32'h05);
    @(negedge clk);
    peek(s); check("frame_len_done", s, 32'h04);

    for (int n = 0; n < 30; n++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * FL) : $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      a = base_v - 32'd8 + 32'($urandom_range(0, 19));
      addr = a;
      #1 check("rand_hit", hit, (a[31:2] == base_v[31:2]) || (a[31:2] == base_v[31:2] + 30'd1));
      peek(s);
      if (!s[1]) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        store(b);
      end
    end

    t = 0;
    peek(s);
    while ((exp_q.size() != 0 || s[0]) && t < 20000) begin
      @(negedge clk);
      peek(s);
      t++;
    end
    check("drain_in_time", t < 20000, 1);
    check("drain_queue", exp_q.size(), 0);
    check("final_status", s, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
